program_loader: RTL

Bit-serial program loader that acts as the writing end of the CPU's RAM load port (`RAM_Write_Data` / `RAM_Write_Address` / `RAM_Write_Enable`). It deserialises 11-bit instruction words from a 1-bit host stream and writes them into RAM rows 0..7. It then checks the RAM contents with an XOR checksum and starts the CPU by driving `PC_Enable`. It sits between the board-level host pins and the CPU top level.

---
 rtl/program_loader.sv | 102 ++++++++++
 1 files changed

// File: rtl/program_loader.sv
// program_loader: deserialises a bit-serial host stream into RAM rows 0..DEPTH-1,
// verifies them with an XOR checksum against RAM readback, then enables the CPU PC.
module program_loader #(
    parameter int WORD_W = 11,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load_start,
    input  logic                      ser_data,
    input  logic                      ser_valid,
    input  logic [DEPTH*WORD_W-1:0]   ram_rdata,
    output logic [WORD_W-1:0]         ram_wdata,
    output logic [ADDR_W-1:0]         ram_waddr,
    output logic                      ram_we,
    output logic                      pc_enable,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [ADDR_W:0]           words_loaded
);
    localparam int CNT_W = $clog2(WORD_W);

    typedef enum logic [2:0] {IDLE, SHIFT, WRITE, VERIFY, RUN, FAIL} state_t;

    state_t              state, nxt;
    logic [WORD_W-2:0]   shreg;
    logic [WORD_W-1:0]   word, sum, rd_sum;
    logic [CNT_W-1:0]    cnt;
    logic                shift_en, last_bit, last_idx, start;

    // ram_waddr doubles as the word index; the last WRITE accepts no bits since no word follows
    assign word     = {shreg, ser_data};
    assign last_idx = ram_waddr == ADDR_W'(DEPTH - 1);
    assign shift_en = ser_valid && (state == SHIFT || (state == WRITE && !last_idx));
    assign last_bit = shift_en && cnt == CNT_W'(WORD_W - 1);
    assign start    = load_start && (state inside {IDLE, RUN, FAIL});

    always_comb begin
        rd_sum = '0;
        for (int i = 0; i < DEPTH; i++)
            rd_sum = rd_sum ^ ram_rdata[i*WORD_W +: WORD_W];
    end

    always_comb begin
        nxt = state;
        case (state)
            SHIFT:   nxt = last_bit ? WRITE : SHIFT;
            WRITE:   nxt = last_idx ? VERIFY : SHIFT;
            VERIFY:  nxt = rd_sum == sum ? RUN : FAIL;
            default: nxt = state;
        endcase
        if (start)
            nxt = SHIFT;
    end

    // outputs are registered from the next state so they change on the same edge as the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            shreg        <= '0;
            cnt          <= '0;
            sum          <= '0;
            ram_wdata    <= '0;
            ram_waddr    <= '0;
            ram_we       <= 1'b0;
            pc_enable    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state     <= nxt;
            ram_we    <= nxt == WRITE;
            busy      <= nxt inside {SHIFT, WRITE, VERIFY};
            done      <= nxt == RUN;
            pc_enable <= nxt == RUN;
            error     <= nxt == FAIL;
            if (start) begin
                cnt          <= '0;
                sum          <= '0;
                ram_waddr    <= '0;
                words_loaded <= '0;
            end else begin
                if (shift_en) begin
                    shreg <= word[WORD_W-2:0];
                    cnt   <= last_bit ? '0 : cnt + 1'b1;
                end
                if (last_bit) begin
                    ram_wdata <= word;
                    sum       <= sum ^ word;
                end
                if (state == WRITE) begin
                    words_loaded <= words_loaded + 1'b1;
                    if (!last_idx)
                        ram_waddr <= ram_waddr + 1'b1;
                end
            end
        end
    end
endmodule
